// File: rtl/lomo_frame_scheduler.sv
// rtl/lomo_frame_scheduler.sv - LOMO telemetry word fetch and serial MK/CLK/DAT scheduler
module lomo_frame_scheduler #(
  parameter int DIV   = 50,
  parameter int WORDS = 20,
  parameter int STRS  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        word_req,
  output logic [4:0]  word_idx,
  output logic [5:0]  str_num,
  output logic [8:0]  frm_num,
  input  logic        word_ack,
  input  logic [15:0] word_data,
  output logic        MK,
  output logic        CLK,
  output logic        DAT,
  output logic        busy,
  output logic        underflow,
  input  logic        clr_uf
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic          phase;     // 0: next tick raises CLK, 1: next tick lowers CLK
  logic [3:0]    bit_cnt;   // bits already completed in the current word
  logic [15:0]   shreg;
  logic          req_pend;  // issue the next request on the following cycle
  logic          buf_valid;
  logic [15:0]   buf_data;
  logic          buf_mk;
  logic          buf_w0;
  logic [5:0]    buf_str;
  logic [8:0]    buf_frm;

  logic [4:0]    nxt_idx;
  logic [5:0]    nxt_str;
  logic [8:0]    nxt_frm;
  logic          tick;
  logic          load_tick;
  logic          cur_first;
  logic          load_w0;

  // Counter values following the current request, with word/string/frame wrap
  always_comb begin
    nxt_idx = word_idx + 5'd1;
    nxt_str = str_num;
    nxt_frm = frm_num;
    if (word_idx == 5'(WORDS - 1)) begin
      nxt_idx = '0;
      nxt_str = str_num + 6'd1;
      if (str_num == 6'(STRS - 1)) begin
        nxt_str = '0;
        nxt_frm = frm_num + 9'd1;
      end
    end
  end

  assign tick      = (div_cnt == DW'(DIV - 1));
  assign load_tick = (state == SHIFT) && tick && phase && (bit_cnt == 4'd15);
  assign cur_first = (word_idx == 5'd0) && (str_num == 6'd0);
  // Word about to be loaded: the buffered one, or the still outstanding request
  assign load_w0   = buf_valid ? buf_w0 : (word_idx == 5'd0);

  // Scheduler state machine, fetch handshake, prefetch buffer and serializer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      div_cnt   <= '0;
      phase     <= 1'b0;
      bit_cnt   <= 4'd0;
      shreg     <= 16'h0000;
      req_pend  <= 1'b0;
      buf_valid <= 1'b0;
      buf_data  <= 16'h0000;
      buf_mk    <= 1'b0;
      buf_w0    <= 1'b0;
      buf_str   <= 6'd0;
      buf_frm   <= 9'd0;
      word_req  <= 1'b0;
      word_idx  <= 5'd0;
      str_num   <= 6'd0;
      frm_num   <= 9'd0;
      MK        <= 1'b0;
      CLK       <= 1'b0;
      DAT       <= 1'b0;
      busy      <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (clr_uf) underflow <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state    <= FETCH;
            word_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          if (word_req && word_ack) begin
            shreg    <= word_data;
            DAT      <= word_data[15];
            CLK      <= 1'b0;
            MK       <= cur_first;
            bit_cnt  <= 4'd0;
            phase    <= 1'b0;
            div_cnt  <= '0;
            word_req <= 1'b0;
            req_pend <= 1'b1;
            word_idx <= nxt_idx;
            str_num  <= nxt_str;
            frm_num  <= nxt_frm;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          div_cnt <= tick ? '0 : div_cnt + 1'b1;
          if (req_pend) begin
            word_req <= 1'b1;
            req_pend <= 1'b0;
          end else if (word_req && word_ack && !load_tick) begin
            buf_valid <= 1'b1;
            buf_data  <= word_data;
            buf_mk    <= cur_first;
            buf_w0    <= (word_idx == 5'd0);
            buf_str   <= str_num;
            buf_frm   <= frm_num;
            word_req  <= 1'b0;
            word_idx  <= nxt_idx;
            str_num   <= nxt_str;
            frm_num   <= nxt_frm;
          end
          if (tick) begin
            phase <= ~phase;
            if (!phase) begin
              CLK <= 1'b1;
            end else begin
              CLK <= 1'b0;
              MK  <= 1'b0;
              if (bit_cnt != 4'd15) begin
                bit_cnt <= bit_cnt + 4'd1;
                shreg   <= shreg << 1;
                DAT     <= shreg[14];
              end else if (!enable && load_w0) begin
                // Stop at a string boundary; the restart re-fetches this word 0
                state     <= IDLE;
                DAT       <= 1'b0;
                word_req  <= 1'b0;
                busy      <= 1'b0;
                req_pend  <= 1'b0;
                buf_valid <= 1'b0;
                phase     <= 1'b0;
                if (buf_valid) begin
                  word_idx <= 5'd0;
                  str_num  <= buf_str;
                  frm_num  <= buf_frm;
                end
              end else begin
                bit_cnt  <= 4'd0;
                req_pend <= 1'b1;
                if (buf_valid) begin
                  shreg     <= buf_data;
                  DAT       <= buf_data[15];
                  MK        <= buf_mk;
                  buf_valid <= 1'b0;
                end else begin
                  // Source missed the slot: send zeros and give up on that word
                  shreg     <= 16'h0000;
                  DAT       <= 1'b0;
                  MK        <= cur_first;
                  underflow <= 1'b1;
                  word_req  <= 1'b0;
                  word_idx  <= nxt_idx;
                  str_num   <= nxt_str;
                  frm_num   <= nxt_frm;
                end
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lomo_frame_scheduler.sv
// tb/tb_lomo_frame_scheduler.sv - directed self-checking bench for lomo_frame_scheduler
module tb_lomo_frame_scheduler;

  logic        clk;
  logic        reset, enable, word_ack, clr_uf;
  logic [15:0] word_data;
  logic        word_req, mk, ser_clk, dat, busy, underflow;
  logic [4:0]  word_idx;
  logic [5:0]  str_num;
  logic [8:0]  frm_num;

  logic        reset2, enable2;
  logic        req2, mk2, clk2, dat2, busy2, uf2;
  logic [4:0]  idx2;
  logic [5:0]  str2;
  logic [8:0]  frm2;
  logic        ack2, clr2;
  logic [15:0] data2;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int src_delay, src_age;
  int wh_en, wh_idx, wh_str, wh_frm;

  lomo_frame_scheduler #(.DIV(2), .WORDS(4), .STRS(3)) dut (
    .clk(clk), .reset(reset), .enable(enable), .word_req(word_req),
    .word_idx(word_idx), .str_num(str_num), .frm_num(frm_num),
    .word_ack(word_ack), .word_data(word_data), .MK(mk), .CLK(ser_clk),
    .DAT(dat), .busy(busy), .underflow(underflow), .clr_uf(clr_uf)
  );

  assign ack2  = req2;
  assign data2 = 16'h0000;
  assign clr2  = 1'b0;

  lomo_frame_scheduler #(.DIV(2), .WORDS(1), .STRS(1)) dut2 (
    .clk(clk), .reset(reset2), .enable(enable2), .word_req(req2),
    .word_idx(idx2), .str_num(str2), .frm_num(frm2),
    .word_ack(ack2), .word_data(data2), .MK(mk2), .CLK(clk2),
    .DAT(dat2), .busy(busy2), .underflow(uf2), .clr_uf(clr2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] fw(input int idx, input int s, input int fr);
    if (fr == 0 && s == 0 && idx == 0) return 16'hA5A5;
    if (fr == 0 && s == 0 && idx == 1) return 16'h1234;
    return 16'hC000 | 16'((fr % 16) << 8) | 16'((s % 16) << 4) | 16'(idx % 16);
  endfunction

  // Word source: acks after src_delay cycles of request, never for the withheld word
  always @(posedge clk) begin
    #1;
    if (word_req && src_age >= src_delay &&
        !(wh_en != 0 && int'(word_idx) == wh_idx && int'(str_num) == wh_str && int'(frm_num) == wh_frm)) begin
      word_ack  = 1'b1;
      word_data = fw(int'(word_idx), int'(str_num), int'(frm_num));
      src_age   = 0;
    end else begin
      word_ack  = 1'b0;
      word_data = 16'h0000;
      src_age   = word_req ? src_age + 1 : 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic read_word(input int start, output logic [15:0] w, output logic mk_s,
                           output logic [15:0] hi, output logic [15:0] lo,
                           output logic [20:0] rq, output logic uf);
    for (int j = 0; j < 16; j++) begin
      wait_cyc(start + 4 * j);
      lo[15-j] = ser_clk;
      if (j == 0) mk_s = mk;
      wait_cyc(start + 4 * j + 1);
      if (j == 0) begin
        rq = {word_req, frm_num, str_num, word_idx};
        uf = underflow;
      end
      wait_cyc(start + 4 * j + 2);
      hi[15-j] = ser_clk;
      w[15-j]  = dat;
    end
  endtask

  initial begin
    logic [15:0] w, hi, lo;
    logic        mk_s, uf;
    logic [20:0] rq;
    int m, m2, st, t, nk;

    reset = 1'b0; enable = 1'b0; clr_uf = 1'b0; reset2 = 1'b0; enable2 = 1'b0;
    word_ack = 1'b0; word_data = 16'h0000;
    src_delay = 0; src_age = 0;
    wh_en = 1; wh_idx = 1; wh_str = 1; wh_frm = 1;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {word_req, word_idx, str_num, frm_num, mk, ser_clk, dat, busy, underflow}, 64'd0);
    reset = 1'b1; reset2 = 1'b1; enable2 = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_without_enable", {word_req, busy}, 64'd0);

    enable = 1'b1;
    @(negedge clk);
    chk("first_req", {word_req, busy, word_idx, str_num, frm_num}, {1'b1, 1'b1, 20'd0});
    m = cyc;

    for (int k = 0; k < 24; k++) begin
      if (k == 13) src_delay = 3;
      if (k == 21) enable = 1'b0;
      st = m + 1 + 64 * k;
      read_word(st, w, mk_s, hi, lo, rq, uf);
      chk($sformatf("word%0d_data", k), w,
          (k == 17 || k == 19) ? 16'h0000 : fw(k % 4, (k / 4) % 3, k / 12));
      chk($sformatf("word%0d_mk", k), mk_s, (k % 12 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("word%0d_clk_shape", k), {hi, lo}, {16'hFFFF, 16'h0000});
      nk = k + 1;
      chk($sformatf("word%0d_next_req", k), rq,
          {1'b1, 9'(nk / 12), 6'((nk / 4) % 3), 5'(nk % 4)});
      chk($sformatf("word%0d_underflow", k), uf, (k >= 17) ? 1'b1 : 1'b0);
      if (k == 17) wh_idx = 3;
      if (k == 18) begin
        wait_cyc(st + 62);
        clr_uf = 1'b1;
        @(negedge clk);
        chk("uf_cleared", underflow, 1'b0);
        @(negedge clk);
        clr_uf = 1'b0;
        chk("uf_set_beats_clear", underflow, 1'b1);
      end
    end

    wait_cyc(m + 1 + 64 * 24 + 1);
    chk("stopped_outputs", {word_req, busy, mk, ser_clk, dat}, 64'd0);
    chk("stopped_counters", {frm_num, str_num, word_idx}, {9'd2, 6'd0, 5'd0});

    src_delay = 0;
    repeat (3) @(negedge clk);
    chk("stay_idle", {word_req, busy}, 64'd0);
    enable = 1'b1;
    @(negedge clk);
    chk("restart_req", {word_req, busy, frm_num, str_num, word_idx}, {1'b1, 1'b1, 9'd2, 6'd0, 5'd0});
    m2 = cyc;
    @(negedge clk);
    chk("restart_load", {dat, ser_clk, busy, word_req, mk}, {1'b1, 1'b0, 1'b1, 1'b0, 1'b1});
    @(negedge clk);
    chk("restart_next_req", {word_req, word_idx, ser_clk}, {1'b1, 5'd1, 1'b0});
    @(negedge clk);
    chk("restart_first_btick", ser_clk, 1'b1);
    read_word(m2 + 65, w, mk_s, hi, lo, rq, uf);
    chk("restart_word1_data", w, fw(1, 0, 2));

    @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("async_reset", {word_req, word_idx, str_num, frm_num, mk, ser_clk, dat, busy, underflow}, 64'd0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_after_reset", {word_req, busy, mk, ser_clk, dat, frm_num, str_num, word_idx}, 64'd0);

    while (frm2 != 9'd511 && cyc < 40000) @(negedge clk);
    chk("frm_reaches_511", frm2, 9'd511);
    t = cyc;
    while (frm2 == 9'd511 && cyc < t + 200) @(negedge clk);
    chk("frm_wraps_to_0", frm2, 9'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lomo_frame_scheduler.md
# lomo_frame_scheduler

Controller that sequences the LOMO serial telemetry output. It paces bit timing from the system clock, walks the word/string/frame counters and fetches each 16-bit payload word from an external word source over a req/ack handshake. It shifts the words out MSB-first on the MK/CLK/DAT serial link. It replaces free-running sync-driven sequencing with a start/stop-controlled, underflow-aware scheduler.

## Interface
- DIV, 50: system clocks per half-bit tick (≥2).
- WORDS, 20: words per string (≤32).
- STRS, 64: strings per frame (≤64).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low.
- enable  in  1  run request, level.
- word_req  out  1  word fetch request.
- word_idx  out  5  index of requested word within string.
- str_num  out  6  string number of requested word.
- frm_num  out  9  frame number of requested word.
- word_ack  in  1  source accepts request; word_data valid this cycle.
- word_data  in  16  payload word.
- MK  out  1  frame marker.
- CLK  out  1  serial bit clock.
- DAT  out  1  serial data.
- busy  out  1  scheduler in FETCH or SHIFT.
- underflow  out  1  sticky, set on missed word.
- clr_uf  in  1  clears underflow.

## Operation
- Reset values: all outputs 0, including counters (word_idx/str_num/frm_num), state IDLE, div counter 0, prefetch buffer empty.
- States:
  - IDLE: enable=1 → FETCH; word_req=1 next cycle with current counters.
  - FETCH: wait for ack (first word of a run only).
  - SHIFT: serialize words.
- Handshake:
  - word_req held with stable idx/str/frm until a cycle with word_req&word_ack; word_data captured that cycle.
  - word_req drops the next cycle.
  - ack with req=0 is ignored.
- Counter advance on each accepted or abandoned request: word_idx +1; at WORDS-1 wrap to 0 and str_num +1; at STRS-1 wrap to 0 and frm_num +1; frm_num wraps 511→0.
- Word load, i.e. the FETCH ack or the SHIFT A-tick after bit 0:
  - Shift register ← word; DAT ← bit15; CLK ← 0.
  - MK ← 1 if word is (str 0, word 0), else 0.
  - Next request issued the following cycle.
- SHIFT ticks every DIV clocks, alternating:
  - B: CLK←1.
  - A: CLK←0, DAT←next bit, MK←0.
- Each bit lasts 2·DIV clocks; each word lasts 32·DIV clocks.
- Prefetched word is held in a 1-entry buffer until its load tick.
- Underflow: at the load tick with buffer empty:
  - Load 16'h0000 and set underflow.
  - Withdraw the outstanding request (word_req←0); its counters count as consumed.
  - Request the following word next cycle.
  - Link timing is never stretched.
- Stop: enable is sampled only at the load tick of word 0 of a string. If 0:
  - Go IDLE; CLK, DAT, MK, word_req and busy ← 0.
  - Discard the buffered word, rewind counters to that word so the restart resumes there.
- clr_uf clears underflow; a simultaneous set wins.
- Reset asserted mid-operation returns everything to reset values immediately (async).

## Timing
- enable↑ sampled at cycle n → word_req=1 at n+1.
- Ack at cycle m → DAT=bit15, CLK=0, busy=1 at m+1; first B-tick at m+1+DIV.
- Next-word request at m+2.
- The source has 32·DIV−2 clocks to ack before underflow.
- Outputs are registered; no combinational paths from inputs to outputs.

## Test plan
- DIV=2, source acks same cycle, enable held: DAT reproduces words 0xA5A5,0x1234 MSB-first with 4-clock bit period. MK=1 only during first bit of (str0, word0). After 20 words str_num=1.
- Run 64×20 words: frm_num 0→1 at str_num wrap; MK pulses once per frame. Force frm_num=511 → wraps to 0.
- Source delays ack 3 clocks per request: no underflow, gapless CLK.
- Source withholds ack for word 5: word 5 shifts 0x0000, underflow=1, next req has word_idx=6. clr_uf in the same cycle as a new underflow leaves underflow=1.
- Drop enable mid-string 2: output continues until word 0 of string 3's load tick, then IDLE with CLK=DAT=0. Re-enable → first req str_num=3, word_idx=0.
- Assert reset mid-word: all outputs 0 asynchronously. After release, idle until enable.
